fc_argmax_collector: RTL and testbench

//  Downstream consumer of the 16-input binarised FC stage. The FC stage has a fixed pipeline

---
 rtl/fc_argmax_collector.sv | 139 +++++++++++++
 tb/tb_fc_argmax_collector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_collector.sv
// Collects the FC stage results for one frame and reports the arg-max class.
// FC results carry no valid, so a token per issued neuron is delayed to line up with fc_out_i.
module fc_argmax_collector #(
  parameter  int FC_LATENCY  = 10,
  parameter  int NUM_CLASSES = 10,
  parameter  int SCORE_W     = 13,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fc_issue_i,
  input  logic                      frame_clr_i,
  input  logic signed [SCORE_W-1:0] fc_out_i,
  output logic                      result_valid_o,
  output logic [IDX_W-1:0]          class_idx_o,
  output logic signed [SCORE_W-1:0] class_score_o,
  output logic                      busy_o,
  output logic                      ovf_err_o
);

  // state | meaning
  // IDLE  | no element of the current frame collected yet
  // ACC   | 1..NUM_CLASSES-1 elements collected, running max valid
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam int ISS_LIMIT = NUM_CLASSES + FC_LATENCY;
  localparam int ISS_W     = $clog2(ISS_LIMIT + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [FC_LATENCY-1:0]     pipe_q, pipe_d;
  logic [0:0]                state_q, state_d;
  logic [IDX_W-1:0]          elem_cnt_q, elem_cnt_d;
  logic signed [SCORE_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]          run_idx_q, run_idx_d;
  logic [IDX_W-1:0]          class_idx_q, class_idx_d;
  logic signed [SCORE_W-1:0] class_score_q, class_score_d;
  logic                      valid_q, valid_d;
  logic [ISS_W-1:0]          iss_cnt_q, iss_cnt_d;
  logic                      ovf_q, ovf_d;

  logic                      tok;
  logic                      better;
  logic signed [SCORE_W-1:0] win_max;
  logic [IDX_W-1:0]          win_idx;

  assign tok = pipe_q[FC_LATENCY-1];

  always_comb begin
    pipe_d        = (pipe_q << 1) | FC_LATENCY'(fc_issue_i);
    state_d       = state_q;
    elem_cnt_d    = elem_cnt_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    valid_d       = 1'b0;
    // Strict compare keeps the lowest index on ties.
    better        = fc_out_i > run_max_q;
    win_max       = better ? fc_out_i : run_max_q;
    win_idx       = better ? elem_cnt_q : run_idx_q;

    if (frame_clr_i) begin
      pipe_d     = '0;
      state_d    = ST_IDLE;
      elem_cnt_d = '0;
      run_max_d  = '0;
      run_idx_d  = '0;
    end else if (tok) begin
      case (state_q)
        ST_IDLE: begin
          run_max_d  = fc_out_i;
          run_idx_d  = '0;
          elem_cnt_d = IDX_W'(1);
          state_d    = ST_ACC;
        end
        default: begin
          run_max_d = win_max;
          run_idx_d = win_idx;
          if (elem_cnt_q == LAST_IDX) begin
            class_score_d = win_max;
            class_idx_d   = win_idx;
            valid_d       = 1'b1;
            elem_cnt_d    = '0;
            state_d       = ST_IDLE;
          end else begin
            elem_cnt_d = elem_cnt_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

  // Issues outstanding; tokens flushed by frame_clr_i are never consumed and stay counted.
  always_comb begin
    iss_cnt_d = iss_cnt_q;
    if (!frame_clr_i) begin
      if (fc_issue_i && !tok && (iss_cnt_q <= ISS_W'(ISS_LIMIT))) begin
        iss_cnt_d = iss_cnt_q + ISS_W'(1);
      end else if (tok && !fc_issue_i && (iss_cnt_q != '0)) begin
        iss_cnt_d = iss_cnt_q - ISS_W'(1);
      end
    end
    ovf_d = ovf_q | (iss_cnt_d > ISS_W'(ISS_LIMIT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q        <= '0;
      state_q       <= ST_IDLE;
      elem_cnt_q    <= '0;
      run_max_q     <= '0;
      run_idx_q     <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      valid_q       <= 1'b0;
      iss_cnt_q     <= '0;
      ovf_q         <= 1'b0;
    end else begin
      pipe_q        <= pipe_d;
      state_q       <= state_d;
      elem_cnt_q    <= elem_cnt_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      valid_q       <= valid_d;
      iss_cnt_q     <= iss_cnt_d;
      ovf_q         <= ovf_d;
    end
  end

  assign result_valid_o = valid_q;
  assign class_idx_o    = class_idx_q;
  assign class_score_o  = class_score_q;
  assign busy_o         = (|pipe_q) | (elem_cnt_q != '0);
  assign ovf_err_o      = ovf_q;

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Bench for fc_argmax_collector: emulates the fixed-latency FC stage and scoreboards results
// against a frame-level argmax model.
module tb_fc_argmax_collector;
  localparam int FC_LATENCY  = 10;
  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 13;
  localparam int IDX_W       = $clog2(NUM_CLASSES);
  localparam int ISS_LIMIT   = NUM_CLASSES + FC_LATENCY;

  logic                      clk = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      fc_issue_i = 1'b0;
  logic                      frame_clr_i = 1'b0;
  logic signed [SCORE_W-1:0] fc_out_i = '0;
  logic                      result_valid_o;
  logic [IDX_W-1:0]          class_idx_o;
  logic signed [SCORE_W-1:0] class_score_o;
  logic                      busy_o;
  logic                      ovf_err_o;

  fc_argmax_collector #(
    .FC_LATENCY (FC_LATENCY),
    .NUM_CLASSES(NUM_CLASSES),
    .SCORE_W    (SCORE_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fc_issue_i    (fc_issue_i),
    .frame_clr_i   (frame_clr_i),
    .fc_out_i      (fc_out_i),
    .result_valid_o(result_valid_o),
    .class_idx_o   (class_idx_o),
    .class_score_o (class_score_o),
    .busy_o        (busy_o),
    .ovf_err_o     (ovf_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int score;
    int edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   fc_sched[int];
  int   frame[$];
  int   issued = 0;
  int   consumed = 0;
  bit   exp_ovf = 1'b0;
  int   model_idx = 0;
  int   model_score = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Frame-level model of one clock edge m.
  task automatic model_edge(input bit iss, input bit clr, input int sc, input int m);
    int best;
    int bi;
    if (clr) begin
      fc_sched.delete();
      frame.delete();
    end else begin
      if (fc_sched.exists(m)) begin
        frame.push_back(fc_sched[m]);
        fc_sched.delete(m);
        consumed++;
        if (frame.size() == NUM_CLASSES) begin
          best = frame[0];
          bi   = 0;
          for (int i = 1; i < NUM_CLASSES; i++) begin
            if (frame[i] > best) begin
              best = frame[i];
              bi   = i;
            end
          end
          exp_q.push_back('{bi, best, m});
          model_idx   = bi;
          model_score = best;
          frame.delete();
        end
      end
      if (iss) begin
        fc_sched[m + FC_LATENCY] = sc;
        issued++;
      end
      if (issued - consumed > ISS_LIMIT) exp_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit iss, input bit clr, input int sc);
    int m;
    m           = cyc + 1;
    fc_issue_i  = iss;
    frame_clr_i = clr;
    fc_out_i    = fc_sched.exists(m) ? SCORE_W'(fc_sched[m]) : SCORE_W'($urandom);
    model_edge(iss, clr, sc, m);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  function automatic int rnd_score(input int lo, input int hi);
    return int'($urandom_range(hi - lo)) + lo;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && result_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got result_valid=1 idx=%0d expected no result (cycle %0d)",
                 class_idx_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.edge_no);
        check("pulse_idx", class_idx_o, e.idx);
        check("pulse_score", class_score_o, e.score);
      end
    end
  end

  int t2[NUM_CLASSES] = '{5, -3, 12, 7, 12, 0, -4096, 1, 2, 3};
  int sv[NUM_CLASSES];

  initial begin
    // Reset with garbage on the inputs.
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fc_issue_i  = 1'(  $urandom);
      frame_clr_i = 1'($urandom);
      fc_out_i    = SCORE_W'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_valid", result_valid_o, 0);
    check("rst_idx", class_idx_o, 0);
    check("rst_score", class_score_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", ovf_err_o, 0);
    rst_i       = 1'b0;
    fc_issue_i  = 1'b0;
    frame_clr_i = 1'b0;
    idle(2);
    check("idle_busy", busy_o, 0);

    // Directed frame with a tie on the maximum.
    for (int i = 0; i < NUM_CLASSES; i++) step(1'b1, 1'b0, t2[i]);
    check("t2_busy_inflight", busy_o, 1);
    idle(FC_LATENCY + 3);
    check("t2_idx", class_idx_o, 2);
    check("t2_score", class_score_o, 12);
    check("t2_busy_done", busy_o, 0);

    // All at the negative limit, then the maximum on the last element.
    for (int i = 0; i < NUM_CLASSES; i++) step(1'b1, 1'b0, -4096);
    idle(FC_LATENCY + 3);
    check("t3_allmin_idx", class_idx_o, 0);
    check("t3_allmin_score", class_score_o, -4096);
    for (int i = 0; i < NUM_CLASSES; i++)
      step(1'b1, 1'b0, (i == NUM_CLASSES - 1) ? 4095 : rnd_score(-4096, 4094));
    idle(FC_LATENCY + 3);
    check("t3_last_idx", class_idx_o, 9);
    check("t3_last_score", class_score_o, 4095);

    // Two frames with no gap between them.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NUM_CLASSES; i++)
        step(1'b1, 1'b0, (i == (f == 0 ? 4 : 7)) ? 2000 : rnd_score(-4096, 1000));
    idle(FC_LATENCY + 3);
    check("t4_idx", class_idx_o, 7);
    check("t4_score", class_score_o, 2000);

    // Abort a partial frame; an issue coincident with the abort is dropped too.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, rnd_score(-4096, 4095));
    step(1'b0, 1'b1, 0);
    check("t5_busy_after_clr", busy_o, 0);
    step(1'b1, 1'b1, 4095);
    check("t5_busy_after_clr_issue", busy_o, 0);
    check("t5_idx_held", class_idx_o, model_idx);
    for (int i = 0; i < NUM_CLASSES; i++) step(1'b1, 1'b0, rnd_score(-4096, 4095));
    check("t5_idx_held_midframe", class_idx_o, 7);
    idle(FC_LATENCY + 3);
    check("t5_fresh_idx", class_idx_o, model_idx);
    check("t5_fresh_score", class_score_o, model_score);
    check("t5_ovf", ovf_err_o, exp_ovf);

    // Sparse issue, then the same scores dense.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NUM_CLASSES; i++) sv[i] = rnd_score(-4096, 4095);
      for (int i = 0; i < NUM_CLASSES; i++) begin
        step(1'b1, 1'b0, sv[i]);
        idle(int'($urandom_range(5)));
      end
      idle(FC_LATENCY + 3);
      check("t6_sparse_idx", class_idx_o, model_idx);
      for (int i = 0; i < NUM_CLASSES; i++) step(1'b1, 1'b0, sv[i]);
      idle(FC_LATENCY + 3);
      check("t6_dense_idx", class_idx_o, model_idx);
      check("t6_dense_score", class_score_o, model_score);
    end
    check("t6_ovf_clear", ovf_err_o, exp_ovf);

    // Overflow: flushed issues are never consumed and accumulate.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd_score(-4096, 4095));
    step(1'b0, 1'b1, 0);
    check("ovf_pre", ovf_err_o, exp_ovf);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, rnd_score(-4096, 4095));
      check("ovf_track", ovf_err_o, exp_ovf);
    end
    check("ovf_set", ovf_err_o, 1);
    step(1'b0, 1'b1, 0);
    idle(3);
    check("ovf_sticky_clr", ovf_err_o, 1);

    // Abort while tokens are arriving: no result, then a clean recovery.
    for (int i = 0; i < NUM_CLASSES; i++) step(1'b1, 1'b0, 3000);
    idle(FC_LATENCY - NUM_CLASSES + 3);
    step(1'b0, 1'b1, 0);
    check("abort_busy", busy_o, 0);
    idle(FC_LATENCY + 3);
    check("abort_idx_held", class_idx_o, model_idx);
    for (int i = 0; i < NUM_CLASSES; i++) step(1'b1, 1'b0, rnd_score(-4096, 4095));
    idle(FC_LATENCY + 3);
    check("recover_idx", class_idx_o, model_idx);
    check("recover_score", class_score_o, model_score);
    check("final_ovf", ovf_err_o, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
